// File: rtl/radix_digit_extractor_if.sv
// Handshake and result bundle between a conversion requester and radix_digit_extractor.
// The master drives start and data; the slave returns busy, done, digits and overflow.
interface radix_digit_extractor_if #(
    parameter int WIDTH      = 13,
    parameter int NUM_DIGITS = 4
);
    logic                    start;
    logic [WIDTH-1:0]        data;
    logic                    busy;
    logic                    done;
    logic [4*NUM_DIGITS-1:0] digits;
    logic                    overflow;

    modport master (
        output start,
        output data,
        input  busy,
        input  done,
        input  digits,
        input  overflow
    );

    modport slave (
        input  start,
        input  data,
        output busy,
        output done,
        output digits,
        output overflow
    );
endinterface

// File: rtl/radix_digit_extractor.sv
// Bit-serial restoring divider that splits an unsigned count into NUM_DIGITS radix-RADIX
// digits, one quotient bit per clock, with overflow flag and optional leading-zero blanking.
module radix_digit_extractor #(
    parameter int WIDTH         = 13,
    parameter int NUM_DIGITS    = 4,
    parameter int RADIX         = 10,
    parameter int LEADING_BLANK = 0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    radix_digit_extractor_if.slave         bus_io
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DW    = 4 * NUM_DIGITS;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [4:0]       RADIX_C   = 5'(RADIX);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_DIVIDE = 1'b1
    } state_t;

    state_t             state_q,  state_d;
    logic [WIDTH-1:0]   w_q,      w_d;
    logic [4:0]         r_q,      r_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [IDX_W-1:0]   idx_q,    idx_d;
    logic [DW-1:0]      shadow_q, shadow_d;
    logic [DW-1:0]      digits_q, digits_d;
    logic               ovf_q,    ovf_d;
    logic               done_q,   done_d;
    logic               busy_q,   busy_d;

    logic [4:0]         r_shift_s;
    logic               q_bit_s;
    logic [4:0]         r_step_s;
    logic [WIDTH-1:0]   w_step_s;

    // Replace zero digits with the blank code from the top down until the first nonzero digit.
    function automatic logic [DW-1:0] blank_leading(input logic [DW-1:0] d);
        logic [DW-1:0] res;
        logic          lead;
        res  = d;
        lead = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            if (lead && (d[4*k +: 4] == 4'h0)) begin
                res[4*k +: 4] = 4'hF;
            end else begin
                lead = 1'b0;
            end
        end
        return res;
    endfunction

    // One restoring-division step: the remainder never exceeds 2*RADIX-1, so 5 bits suffice.
    always_comb begin
        r_shift_s = 5'({r_q, w_q[WIDTH-1]});
        q_bit_s   = (r_shift_s >= RADIX_C);
        if (q_bit_s) begin
            r_step_s = r_shift_s - RADIX_C;
        end else begin
            r_step_s = r_shift_s;
        end
        w_step_s = {w_q[WIDTH-2:0], q_bit_s};
    end

    // Next-state, datapath and output update for the IDLE/DIVIDE controller.
    always_comb begin
        state_d  = state_q;
        w_d      = w_q;
        r_d      = r_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        digits_d = digits_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        busy_d   = busy_q;

        case (state_q)
            S_IDLE: begin
                if (bus_io.start) begin
                    w_d     = bus_io.data;
                    r_d     = 5'd0;
                    cnt_d   = CNT_LAST;
                    idx_d   = {IDX_W{1'b0}};
                    busy_d  = 1'b1;
                    state_d = S_DIVIDE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DIVIDE: begin
                w_d = w_step_s;
                r_d = r_step_s;
                if (cnt_q == {CNT_W{1'b0}}) begin
                    // Digit boundary: the remainder is this digit, the quotient is the next dividend.
                    shadow_d[4*idx_q +: 4] = r_step_s[3:0];
                    r_d   = 5'd0;
                    cnt_d = CNT_LAST;
                    if (idx_q == IDX_LAST) begin
                        ovf_d = (w_step_s != {WIDTH{1'b0}});
                        if ((LEADING_BLANK != 0) && !ovf_d) begin
                            digits_d = blank_leading(shadow_d);
                        end else begin
                            digits_d = shadow_d;
                        end
                        idx_d   = {IDX_W{1'b0}};
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any conversion in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            w_q      <= {WIDTH{1'b0}};
            r_q      <= 5'd0;
            cnt_q    <= {CNT_W{1'b0}};
            idx_q    <= {IDX_W{1'b0}};
            shadow_q <= {DW{1'b0}};
            digits_q <= {DW{1'b0}};
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            w_q      <= w_d;
            r_q      <= r_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            digits_q <= digits_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign bus_io.busy     = busy_q;
    assign bus_io.done     = done_q;
    assign bus_io.digits   = digits_q;
    assign bus_io.overflow = ovf_q;

endmodule

// File: tb/tb_radix_digit_extractor.sv
// Scoreboard bench for radix_digit_extractor across default, blanking, 3-digit and hex builds.
module tb_radix_digit_extractor;

    logic clk;
    logic rst_n;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    radix_digit_extractor_if #(.WIDTH(13), .NUM_DIGITS(4)) if_a ();
    radix_digit_extractor_if #(.WIDTH(13), .NUM_DIGITS(4)) if_b ();
    radix_digit_extractor_if #(.WIDTH(13), .NUM_DIGITS(3)) if_c ();
    radix_digit_extractor_if #(.WIDTH(13), .NUM_DIGITS(4)) if_d ();

    radix_digit_extractor #(.WIDTH(13), .NUM_DIGITS(4), .RADIX(10), .LEADING_BLANK(0))
        u_a (.clk(clk), .rst_n(rst_n), .bus_io(if_a));
    radix_digit_extractor #(.WIDTH(13), .NUM_DIGITS(4), .RADIX(10), .LEADING_BLANK(1))
        u_b (.clk(clk), .rst_n(rst_n), .bus_io(if_b));
    radix_digit_extractor #(.WIDTH(13), .NUM_DIGITS(3), .RADIX(10), .LEADING_BLANK(1))
        u_c (.clk(clk), .rst_n(rst_n), .bus_io(if_c));
    radix_digit_extractor #(.WIDTH(13), .NUM_DIGITS(4), .RADIX(16), .LEADING_BLANK(0))
        u_d (.clk(clk), .rst_n(rst_n), .bus_io(if_d));

    // Expected {overflow, digits} per instance, plus expected Done cycle for instance a.
    logic [32:0] q_a[$], q_b[$], q_c[$], q_d[$];
    int          lat_a[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: Done pulsed with no conversion outstanding (cycle %0d)", name, cyc);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pulse start on one instance for a single edge and report the acceptance cycle.
    task automatic issue(input int dut, input logic [12:0] val, output int e0);
        case (dut)
            0: begin if_a.data = val; if_a.start = 1'b1; end
            1: begin if_b.data = val; if_b.start = 1'b1; end
            2: begin if_c.data = val; if_c.start = 1'b1; end
            default: begin if_d.data = val; if_d.start = 1'b1; end
        endcase
        tick(1);
        e0 = cyc;
        if_a.start = 1'b0;
        if_b.start = 1'b0;
        if_c.start = 1'b0;
        if_d.start = 1'b0;
    endtask

    // Monitors: compare every published result against the head of its queue.
    always @(negedge clk) begin
        if (if_a.done) begin
            if (q_a.size() == 0) begin
                unexpected("a_done");
            end else begin
                check("a_result", {if_a.overflow, 32'(if_a.digits)}, q_a.pop_front());
                check("a_latency", cyc, (lat_a.size() != 0) ? lat_a.pop_front() : -1);
                check("a_busy_in_done", if_a.busy, 1'b0);
            end
        end
    end

    always @(negedge clk) begin
        if (if_b.done) begin
            if (q_b.size() == 0) unexpected("b_done");
            else check("b_result", {if_b.overflow, 32'(if_b.digits)}, q_b.pop_front());
        end
    end

    always @(negedge clk) begin
        if (if_c.done) begin
            if (q_c.size() == 0) unexpected("c_done");
            else check("c_result", {if_c.overflow, 32'(if_c.digits)}, q_c.pop_front());
        end
    end

    always @(negedge clk) begin
        if (if_d.done) begin
            if (q_d.size() == 0) unexpected("d_done");
            else check("d_result", {if_d.overflow, 32'(if_d.digits)}, q_d.pop_front());
        end
    end

    logic [12:0] b_in  [4] = '{13'd42, 13'd0, 13'd1000, 13'd305};
    logic [32:0] b_exp [4] = '{{1'b0, 32'hFF42}, {1'b0, 32'hFFF0}, {1'b0, 32'h1000}, {1'b0, 32'hF305}};
    logic [12:0] c_in  [4] = '{13'd8191, 13'd5, 13'd999, 13'd1000};
    logic [32:0] c_exp [4] = '{{1'b1, 32'h191}, {1'b0, 32'hFF5}, {1'b0, 32'h999}, {1'b1, 32'h000}};
    logic [12:0] d_in  [3] = '{13'h1ABC, 13'h1FFF, 13'h0000};
    logic [32:0] d_exp [3] = '{{1'b0, 32'h1ABC}, {1'b0, 32'h1FFF}, {1'b0, 32'h0000}};
    logic [12:0] a_in  [2] = '{13'd8191, 13'd0};
    logic [32:0] a_exp [2] = '{{1'b0, 32'h8191}, {1'b0, 32'h0000}};

    initial begin
        int e0;
        rst_n = 1'b0;
        if_a.start = 1'b0; if_a.data = 13'd0;
        if_b.start = 1'b0; if_b.data = 13'd0;
        if_c.start = 1'b0; if_c.data = 13'd0;
        if_d.start = 1'b0; if_d.data = 13'd0;
        tick(3);
        check("rst_busy", if_a.busy, 1'b0);
        check("rst_done", if_a.done, 1'b0);
        check("rst_digits", if_a.digits, 16'h0000);
        check("rst_overflow", if_a.overflow, 1'b0);
        rst_n = 1'b1;
        tick(2);

        // Basic conversion with an ignored Start at cycle 20 of the run.
        q_a.push_back({1'b0, 32'h1234});
        issue(0, 13'd1234, e0);
        lat_a.push_back(e0 + 52);
        tick(10);
        check("a_busy_mid", if_a.busy, 1'b1);
        tick(10);
        if_a.data  = 13'd999;
        if_a.start = 1'b1;
        tick(1);
        if_a.start = 1'b0;
        tick(40);

        foreach (b_in[i]) begin
            q_b.push_back(b_exp[i]);
            issue(1, b_in[i], e0);
            tick(56);
        end
        foreach (c_in[i]) begin
            q_c.push_back(c_exp[i]);
            issue(2, c_in[i], e0);
            tick(45);
        end
        foreach (d_in[i]) begin
            q_d.push_back(d_exp[i]);
            issue(3, d_in[i], e0);
            tick(56);
        end
        foreach (a_in[i]) begin
            q_a.push_back(a_exp[i]);
            issue(0, a_in[i], e0);
            lat_a.push_back(e0 + 52);
            tick(56);
        end

        // Start held high: re-acceptance on the edge ending the Done cycle.
        q_a.push_back({1'b0, 32'h1234});
        q_a.push_back({1'b0, 32'h4321});
        if_a.data  = 13'd1234;
        if_a.start = 1'b1;
        tick(1);
        e0 = cyc;
        lat_a.push_back(e0 + 52);
        lat_a.push_back(e0 + 105);
        tick(10);
        if_a.data = 13'd4321;
        tick(43);
        if_a.start = 1'b0;
        tick(27);
        check("a_hold_digits", if_a.digits, 16'h1234);
        check("a_hold_busy", if_a.busy, 1'b1);
        tick(35);

        // Reset mid-conversion aborts without a Done.
        issue(0, 13'd5555, e0);
        tick(29);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", if_a.busy, 1'b0);
        check("abort_done", if_a.done, 1'b0);
        check("abort_digits", if_a.digits, 16'h0000);
        check("abort_overflow", if_a.overflow, 1'b0);
        #3 rst_n = 1'b1;
        tick(60);
        q_a.push_back({1'b0, 32'h0007});
        issue(0, 13'd7, e0);
        lat_a.push_back(e0 + 52);
        tick(56);

        check("a_pending", q_a.size(), 0);
        check("b_pending", q_b.size(), 0);
        check("c_pending", q_c.size(), 0);
        check("d_pending", q_d.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
